mod_updown_counter: RTL and testbench

Parametrised modulo up/down counter with synchronous clear, parallel load, enable prescaler and a terminal-count pulse. It replaces the fixed 4-bit free-running counter wherever a design needs a programmable modulus, counting direction or tick rate: timers, BCD digit chains and event dividers. Several instances can be cascaded by wiring one stage's `tc` into the next stage's `en`.

---
 rtl/mod_updown_counter.sv | 137 +++++++++++++
 tb/tb_mod_updown_counter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_updown_counter.sv
// -----------------------------------------------------------------------------
// mod_updown_counter
//
// Parametrised modulo up/down counter with synchronous clear, parallel load,
// an enable prescaler and a registered terminal-count pulse. Intended for
// timers, BCD digit chains and event dividers. Stages cascade by wiring one
// stage's tc into the next stage's en (one cycle of skew per stage).
//
// Defining MUDC_SAT_EN adds the sat input and at_bound output; with sat=1 a
// step that would wrap is held at the bound instead, without tc.
// -----------------------------------------------------------------------------
module mod_updown_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 16,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
`ifdef MUDC_SAT_EN
  input  logic             sat,
  output logic             at_bound,
`endif
  output logic [WIDTH-1:0] out,
  output logic             tc
);

  // One extra bit so that MOD = 2**WIDTH is representable and the
  // increment/decrement carry and borrow are visible without truncation.
  localparam int             XW    = WIDTH + 1;
  localparam logic [XW-1:0]  MOD_X = XW'(MOD);
  localparam logic [XW-1:0]  TOP_X = XW'(MOD - 1);

  logic [XW-1:0]    inc_x;
  logic [XW-1:0]    dec_x;
  logic [XW-1:0]    ld_x;
  logic             at_top;
  logic             at_zero;
  logic             at_edge;
  logic             presc_last;
  logic             hold_step;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_clamped;

  // Next-value arithmetic. The wrap test uses the widened sum against MOD
  // (not MOD-1 against the narrow count) and the borrow bit of the widened
  // difference, so both directions stay correct when MOD = 2**WIDTH.
  always_comb begin
    inc_x        = {1'b0, out} + XW'(1);
    dec_x        = {1'b0, out} - XW'(1);
    ld_x         = {1'b0, load_val};
    at_top       = (inc_x == MOD_X);
    at_zero      = dec_x[WIDTH];
    at_edge      = up ? at_top : at_zero;
    step_val     = '0;
    if (up) begin
      step_val = at_top ? '0 : inc_x[WIDTH-1:0];
    end else begin
      step_val = at_zero ? TOP_X[WIDTH-1:0] : dec_x[WIDTH-1:0];
    end
    load_clamped = (ld_x >= MOD_X) ? TOP_X[WIDTH-1:0] : load_val;
  end

  // Prescaler: counts enabled cycles and marks the last one of each DIV
  // period as the step cycle. clr/load restart the period; a change of
  // direction does not. With DIV=1 there is no register at all.
  generate
    if (DIV > 1) begin : g_presc
      localparam int            PW    = $clog2(DIV);
      localparam logic [PW-1:0] PLAST = PW'(DIV - 1);

      logic [PW-1:0] presc;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          presc <= '0;
        end else if (clr || load) begin
          presc <= '0;
        end else if (en) begin
          presc <= (presc == PLAST) ? '0 : presc + PW'(1);
        end
      end

      assign presc_last = (presc == PLAST);
    end else begin : g_nopresc
      assign presc_last = 1'b1;
    end
  endgenerate

  // A step at the bound is held instead of wrapping when saturation is on.
`ifdef MUDC_SAT_EN
  assign hold_step = sat & at_edge;
`else
  assign hold_step = 1'b0;
`endif

  // Count register and terminal-count pulse. tc is only ever set on the
  // edge that produces the wrapped value, so it is coincident with it and
  // cleared on every other edge, including clr/load in a would-be wrap cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out <= '0;
      tc  <= 1'b0;
    end else if (clr) begin
      out <= '0;
      tc  <= 1'b0;
    end else if (load) begin
      out <= load_clamped;
      tc  <= 1'b0;
    end else if (en && presc_last) begin
      if (hold_step) begin
        tc <= 1'b0;
      end else begin
        out <= step_val;
        tc  <= at_edge;
      end
    end else begin
      tc <= 1'b0;
    end
  end

`ifdef MUDC_SAT_EN
  // Set for exactly the cycles that follow a suppressed step.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      at_bound <= 1'b0;
    end else begin
      at_bound <= !clr && !load && en && presc_last && hold_step;
    end
  end
`endif

endmodule

// File: tb/tb_mod_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_updown_counter
//
// Three counter instances share one stimulus stream:
//   u0 : WIDTH=4 MOD=10 DIV=1
//   u1 : WIDTH=4 MOD=4  DIV=3
//   u2 : WIDTH=4 MOD=16 DIV=2  (modulus equal to 2**WIDTH)
// A reference model using plain modulo arithmetic tracks each instance.
// -----------------------------------------------------------------------------
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       rstn;
  logic       clr;
  logic       load;
  logic [3:0] load_val;
  logic       en;
  logic       up;
`ifdef MUDC_SAT_EN
  logic       sat;
  logic       ab0, ab1, ab2;
`endif
  logic [3:0] o0, o1, o2;
  logic       tc0, tc1, tc2;

  int tests = 0;
  int fails = 0;

  int mods[3] = '{10, 4, 16};
  int divs[3] = '{1, 3, 2};
  int mcnt[3];
  int mpre[3];
  int mtc[3];
  int mab[3];

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(4), .MOD(10), .DIV(1)) u0 (
    .clk(clk), .rstn(rstn), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up),
`ifdef MUDC_SAT_EN
    .sat(sat), .at_bound(ab0),
`endif
    .out(o0), .tc(tc0));

  mod_updown_counter #(.WIDTH(4), .MOD(4), .DIV(3)) u1 (
    .clk(clk), .rstn(rstn), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up),
`ifdef MUDC_SAT_EN
    .sat(sat), .at_bound(ab1),
`endif
    .out(o1), .tc(tc1));

  mod_updown_counter #(.WIDTH(4), .MOD(16), .DIV(2)) u2 (
    .clk(clk), .rstn(rstn), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up),
`ifdef MUDC_SAT_EN
    .sat(sat), .at_bound(ab2),
`endif
    .out(o2), .tc(tc2));

  function automatic logic [31:0] obs_out(input int i);
    case (i)
      0:       return {28'd0, o0};
      1:       return {28'd0, o1};
      default: return {28'd0, o2};
    endcase
  endfunction

  function automatic logic [31:0] obs_tc(input int i);
    case (i)
      0:       return {31'd0, tc0};
      1:       return {31'd0, tc1};
      default: return {31'd0, tc2};
    endcase
  endfunction

`ifdef MUDC_SAT_EN
  function automatic logic [31:0] obs_ab(input int i);
    case (i)
      0:       return {31'd0, ab0};
      1:       return {31'd0, ab1};
      default: return {31'd0, ab2};
    endcase
  endfunction
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mcnt[i] = 0;
      mpre[i] = 0;
      mtc[i]  = 0;
      mab[i]  = 0;
    end
  endtask

  // Behavioural model of one clock edge, from the counter's rules.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      bit s;
      bit bnd;
      s = 1'b0;
`ifdef MUDC_SAT_EN
      s = (sat === 1'b1);
`endif
      mtc[i] = 0;
      mab[i] = 0;
      if (clr) begin
        mcnt[i] = 0;
        mpre[i] = 0;
      end else if (load) begin
        mcnt[i] = (int'(load_val) >= mods[i]) ? mods[i] - 1 : int'(load_val);
        mpre[i] = 0;
      end else if (en) begin
        if (mpre[i] < divs[i] - 1) begin
          mpre[i]++;
        end else begin
          mpre[i] = 0;
          bnd = up ? (mcnt[i] == mods[i] - 1) : (mcnt[i] == 0);
          if (bnd && s) begin
            mab[i] = 1;
          end else begin
            mcnt[i] = up ? (mcnt[i] + 1) % mods[i] : (mcnt[i] + mods[i] - 1) % mods[i];
            mtc[i]  = bnd ? 1 : 0;
          end
        end
      end
    end
  endtask

  task automatic check_all(input string ctx);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s.u%0d.out", ctx, i), obs_out(i), mcnt[i]);
      chk($sformatf("%s.u%0d.tc", ctx, i), obs_tc(i), mtc[i]);
`ifdef MUDC_SAT_EN
      chk($sformatf("%s.u%0d.at_bound", ctx, i), obs_ab(i), mab[i]);
`endif
    end
  endtask

  // One clock edge: update the model with the sampled inputs, then check
  // shortly after the edge.
  task automatic cyc(input string ctx);
    @(posedge clk);
    model_edge();
    #1;
    check_all(ctx);
  endtask

  int seq0[12]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int seq1[12]  = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
  int rst1[6]   = '{0, 0, 1, 1, 1, 2};
  int down0[3]  = '{9, 8, 7};

  initial begin
    rstn = 1'b0; clr = 1'b0; load = 1'b0; load_val = 4'd0; en = 1'b0; up = 1'b1;
`ifdef MUDC_SAT_EN
    sat = 1'b0;
`endif
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rstn = 1'b1;

    // Count up 12 cycles
    en = 1'b1; up = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cyc("up");
      chk($sformatf("plan.up.u0.out[%0d]", k), obs_out(0), seq0[k]);
      chk($sformatf("plan.up.u0.tc[%0d]", k), obs_tc(0), (k == 9) ? 1 : 0);
      chk($sformatf("plan.up.u1.out[%0d]", k), obs_out(1), seq1[k]);
      chk($sformatf("plan.up.u1.tc[%0d]", k), obs_tc(1), (k == 11) ? 1 : 0);
    end

    // Clear, then count down from 0
    clr = 1'b1;
    cyc("clr");
    clr = 1'b0; up = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc("down");
      chk($sformatf("plan.down.u0.out[%0d]", k), obs_out(0), down0[k]);
      chk($sformatf("plan.down.u0.tc[%0d]", k), obs_tc(0), (k == 0) ? 1 : 0);
    end

    // Load clamp, clr over load, load over a would-be wrap
    en = 1'b0; load = 1'b1; load_val = 4'd12;
    cyc("load12");
    chk("plan.load12.u0", obs_out(0), 9);
    chk("plan.load12.u1", obs_out(1), 3);
    chk("plan.load12.u2", obs_out(2), 12);
    clr = 1'b1;
    cyc("loadclr");
    chk("plan.loadclr.u0", obs_out(0), 0);
    clr = 1'b0; load_val = 4'd9;
    cyc("load9");
    load_val = 4'd5; en = 1'b1; up = 1'b1;
    cyc("loadwrap");
    chk("plan.loadwrap.u0.out", obs_out(0), 5);
    chk("plan.loadwrap.u0.tc", obs_tc(0), 0);
    load = 1'b0;
    for (int k = 0; k < 4; k++) cyc("after_load");

    // Asynchronous reset between edges, then a full prescale period
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc("post_rst");
      chk($sformatf("plan.post_rst.u1.out[%0d]", k), obs_out(1), rst1[k]);
    end

`ifdef MUDC_SAT_EN
    // Saturation at the top bound, then release to wrap
    load = 1'b1; load_val = 4'd8; sat = 1'b1; up = 1'b1; en = 1'b1;
    cyc("sat_load");
    load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc("sat_hold");
      chk($sformatf("plan.sat.u0.out[%0d]", k), obs_out(0), 9);
      chk($sformatf("plan.sat.u0.tc[%0d]", k), obs_tc(0), 0);
      chk($sformatf("plan.sat.u0.at_bound[%0d]", k), obs_ab(0), (k == 0) ? 0 : 1);
    end
    sat = 1'b0;
    cyc("sat_release");
    chk("plan.sat_release.u0.out", obs_out(0), 0);
    chk("plan.sat_release.u0.tc", obs_tc(0), 1);
    chk("plan.sat_release.u0.at_bound", obs_ab(0), 0);
`endif

    // Randomized traffic
    for (int k = 0; k < 2000; k++) begin
      clr      = ($urandom_range(31) == 0);
      load     = ($urandom_range(15) == 0);
      load_val = 4'($urandom_range(15));
      en       = ($urandom_range(3) != 0);
      if ($urandom_range(7) == 0) up = ~up;
`ifdef MUDC_SAT_EN
      if ($urandom_range(15) == 0) sat = ~sat;
`endif
      if (k == 1000) begin
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        check_all("rand_rst");
        @(negedge clk);
        rstn = 1'b1;
      end
      cyc("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
